// File: rtl/chart_sequencer.sv
// chart_sequencer
//   Plays back a note chart held in ROM. For each 14-bit entry
//   {note_code[3:0], delay[9:0]} it emits the note code as a one-cycle
//   spawn pulse, then waits `delay` unpaused game frames before fetching
//   the next entry. Playback ends on an entry whose delay equals END_DELAY,
//   or after the entry at address MAX_PC.
//
// Ports
//   clk        system clock
//   rst        synchronous active-high reset
//   start      begin playback from pc=0 (honoured only in IDLE or DONE)
//   pause      level; freezes the frame countdown
//   frame_tick one-cycle pulse per game frame
//   data       chart ROM word for the current pc (combinational)
//   pc         chart ROM address
//   note_valid one-cycle pulse, note_code carries a new note
//   note_code  lane/colour code of the most recent entry (held)
//   busy       high from FETCH through WAIT
//   done       high in DONE
module chart_sequencer #(
  parameter int ADDR_W    = 8,
  parameter int MAX_PC    = 156,
  parameter int END_DELAY = 1000,
  parameter int CODE_NONE = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              pause,
  input  logic              frame_tick,
  input  logic [13:0]       data,
  output logic [ADDR_W-1:0] pc,
  output logic              note_valid,
  output logic [3:0]        note_code,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {IDLE, FETCH, EMIT, WAIT, DONE} state_t;

  localparam logic [ADDR_W-1:0] LAST_PC = ADDR_W'(MAX_PC);
  localparam logic [9:0]        END_D   = 10'(END_DELAY);
  localparam logic [3:0]        NONE    = 4'(CODE_NONE);

  state_t     state;
  logic [9:0] delay_r;
  logic [9:0] cnt;

  // note_code doubles as the registered code of the current entry: it is
  // loaded in FETCH so the pulse and the code appear together in EMIT,
  // and it naturally holds afterwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      pc         <= '0;
      note_valid <= 1'b0;
      note_code  <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      delay_r    <= '0;
      cnt        <= '0;
    end else begin
      note_valid <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state <= FETCH;
            pc    <= '0;
            busy  <= 1'b1;
            done  <= 1'b0;
          end
        end
        FETCH: begin
          note_code  <= data[13:10];
          note_valid <= (data[13:10] != NONE);
          delay_r    <= data[9:0];
          state      <= EMIT;
        end
        EMIT: begin
          if (delay_r == END_D) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            cnt   <= delay_r;
            state <= WAIT;
          end
        end
        WAIT: begin
          // Expiry wins over a coincident tick; that tick is simply dropped.
          // MAX_PC is checked before incrementing, so pc never wraps.
          if (cnt == '0) begin
            if (pc == LAST_PC) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              pc    <= pc + 1'b1;
              state <= FETCH;
            end
          end else if (frame_tick && !pause) begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
